lfsr: RTL and testbench

// - Free-running Fibonacci LFSR pseudo-random source; advances one step every clk cycle.
// - Feeds random gap positions to the obstacle generator, which samples out opportunistically.
// - Two instances with equal SEED produce identical sequences; use distinct SEEDs for independence.

---
 rtl/lfsr_pkg.sv | 34 +++
 rtl/lfsr_next.sv | 25 ++
 rtl/lfsr.sv | 65 ++++++
 tb/tb_lfsr.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR block: legal width range and the table of
// maximal-length XNOR tap masks indexed by register width.
package lfsr_pkg;

   localparam int LFSR_MIN_W = 3;
   localparam int LFSR_MAX_W = 16;

   // Maximal-length XNOR tap mask for a w-bit register. Bit i set means
   // state[i] participates in the feedback. Returns zero for unsupported w,
   // which the top-level elaboration checks reject.
   function automatic logic [LFSR_MAX_W-1:0] taps(input int w);
      logic [LFSR_MAX_W-1:0] mask;
      mask = '0;
      case (w)
         3:  mask = 16'b0000_0000_0000_0110;
         4:  mask = 16'b0000_0000_0000_1100;
         5:  mask = 16'b0000_0000_0001_0100;
         6:  mask = 16'b0000_0000_0011_0000;
         7:  mask = 16'b0000_0000_0110_0000;
         8:  mask = 16'b0000_0000_1011_1000;
         9:  mask = 16'b0000_0001_0001_0000;
         10: mask = 16'b0000_0010_0100_0000;
         11: mask = 16'b0000_0101_0000_0000;
         12: mask = 16'b0000_1000_0010_1001;
         13: mask = 16'b0001_0000_0000_1101;
         14: mask = 16'b0010_0000_0001_0101;
         15: mask = 16'b0110_0000_0000_0000;
         16: mask = 16'b1101_0000_0000_1000;
         default: mask = '0;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of a Fibonacci XNOR LFSR: the tapped
// bits are XNOR-reduced and the result shifts in at the LSB.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int                WIDTH = 3,
   parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(lfsr_pkg::taps(WIDTH))
) (
   input  logic [WIDTH-1:0] state,
   output logic [WIDTH-1:0] next_state
);

   logic [WIDTH-1:0] tapped;
   logic             fb;

   // Mask each state bit with its tap enable.
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_tap
      assign tapped[gi] = state[gi] & TAPS[gi];
   end

   // XNOR feedback keeps all-zeros inside the sequence; all-ones is the lock-up state.
   assign fb         = ~^tapped;
   assign next_state = {state[WIDTH-2:0], fb};

endmodule

// File: rtl/lfsr.sv
// Free-running Fibonacci LFSR pseudo-random source. Advances one step every
// clock; reset reloads SEED on the same edge.
// Build option: define LFSR_LOCKUP_RECOVER_EN to reload SEED whenever the
// register is found in the all-ones lock-up state; otherwise that state is
// sticky until reset.
module lfsr
   import lfsr_pkg::*;
#(
   parameter int                WIDTH = 3,
   parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(lfsr_pkg::taps(WIDTH)),
   parameter logic [WIDTH-1:0]  SEED  = '0
) (
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] out
);

   logic [WIDTH-1:0] state_reg;
   logic [WIDTH-1:0] state_next;
   logic [WIDTH-1:0] step_value;

   // Reject configurations that cannot produce a usable sequence.
   if (WIDTH < LFSR_MIN_W || WIDTH > LFSR_MAX_W) begin : g_bad_width
      $error("lfsr: WIDTH %0d outside %0d..%0d", WIDTH, LFSR_MIN_W, LFSR_MAX_W);
   end
   if (TAPS == '0) begin : g_bad_taps_zero
      $error("lfsr: TAPS must not be zero");
   end
   if (TAPS[WIDTH-1] != 1'b1) begin : g_bad_taps_msb
      $error("lfsr: TAPS must include the MSB");
   end
   if (SEED == {WIDTH{1'b1}}) begin : g_bad_seed
      $error("lfsr: SEED must not be all-ones (lock-up state)");
   end

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS)
   ) u_next (
      .state      (state_reg),
      .next_state (step_value)
   );

   // Select the value loaded on the next non-reset edge.
   always_comb begin
      state_next = step_value;
`ifdef LFSR_LOCKUP_RECOVER_EN
      if (&state_reg) begin
         state_next = SEED;
      end
`endif
   end

   // State register with synchronous reload of SEED.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= SEED;
      end else begin
         state_reg <= state_next;
      end
   end

   assign out = state_reg;

endmodule

// File: tb/tb_lfsr.sv
// Scoreboard bench for lfsr: the stimulus process pushes hand-computed
// expected outputs, a monitor pops and compares one entry per clock.
// Honours LFSR_LOCKUP_RECOVER_EN to choose the lock-up expectation.
module tb_lfsr;

   logic       clk;
   logic       reset;
   logic [2:0] out_a;
   logic [2:0] out_b;
   logic [7:0] out_8;

   lfsr #(.WIDTH(3), .SEED(3'b000)) u_a (.clk(clk), .reset(reset), .out(out_a));
   lfsr #(.WIDTH(3), .SEED(3'b101)) u_b (.clk(clk), .reset(reset), .out(out_b));
   lfsr #(.WIDTH(8), .SEED(8'h00))  u_8 (.clk(clk), .reset(reset), .out(out_8));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      bit         ca;
      bit         cb;
      bit         c8;
      logic [2:0] ea;
      logic [2:0] eb;
      logic [7:0] e8;
   } exp_t;

   exp_t sb[$];

   int n_vec = 0;
   int n_bad = 0;

   // Hand-computed WIDTH=3 sequence starting from 000; SEED 101 sits at index 4.
   logic [2:0] seq3 [7] = '{3'b000, 3'b001, 3'b011, 3'b110, 3'b101, 3'b010, 3'b100};
   int ia = 0;
   int ib = 4;

   // Period tracking for the 8-bit instance.
   bit per_en    = 1'b0;
   int per_steps = 0;
   int first_ret = 0;
   int ff_seen   = 0;
   int seen [256];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %b, expected %b", name, act, req);
      end
   endtask

   task automatic step(input logic rst, input string tag,
                       input bit ca, input logic [2:0] ea,
                       input bit cb, input logic [2:0] eb,
                       input bit c8, input logic [7:0] e8);
      exp_t e;
      e.tag = tag; e.ca = ca; e.cb = cb; e.c8 = c8;
      e.ea = ea;   e.eb = eb; e.e8 = e8;
      reset = rst;
      sb.push_back(e);
      @(negedge clk);
   endtask

   task automatic reset_step(input string tag);
      ia = 0;
      ib = 4;
      step(1'b1, tag, 1'b1, 3'b000, 1'b1, 3'b101, 1'b1, 8'h00);
   endtask

   task automatic run_seq(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         ia = (ia + 1) % 7;
         ib = (ib + 1) % 7;
         step(1'b0, tag, 1'b1, seq3[ia], 1'b1, seq3[ib], 1'b0, 8'h00);
      end
   endtask

   // Monitor: one scoreboard entry per clock, sampled just after the edge.
   initial begin
      exp_t e;
      for (int i = 0; i < 256; i++) seen[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.ca) check({e.tag, ".a"}, {5'b0, out_a}, {5'b0, e.ea});
            if (e.cb) check({e.tag, ".b"}, {5'b0, out_b}, {5'b0, e.eb});
            if (e.c8) check({e.tag, ".w8"}, out_8, e.e8);
            $display("vec %-8s rst=%b a=%b b=%b w8=%h", e.tag, reset, out_a, out_b, out_8);
         end
         if (per_en) begin
            per_steps++;
            if (out_8 === 8'hff) ff_seen++;
            if (out_8 === 8'h00 && first_ret == 0) first_ret = per_steps;
            if (per_steps <= 255 && !$isunknown(out_8)) seen[out_8]++;
         end
      end
   end

   // Stimulus.
   initial begin
      int distinct;
      reset = 1'b1;

      // Reset held two cycles.
      reset_step("reset");
      reset_step("reset");

      // Two full periods after release.
      run_seq(14, "seq");

      // Advance to a=101, then reset mid-run and release.
      run_seq(4, "pre_mid");
      reset_step("mid_rst");
      run_seq(1, "post_mid");

      // Lock-up: drive instance a into all-ones.
      force u_a.state_reg = 3'b111;
      #1;
      release u_a.state_reg;
`ifdef LFSR_LOCKUP_RECOVER_EN
      ia = 0;
      ib = (ib + 1) % 7;
      step(1'b0, "recover", 1'b1, 3'b000, 1'b1, seq3[ib], 1'b0, 8'h00);
      run_seq(2, "after_rc");
`else
      for (int i = 0; i < 10; i++) begin
         ib = (ib + 1) % 7;
         step(1'b0, "lockup", 1'b1, 3'b111, 1'b1, seq3[ib], 1'b0, 8'h00);
      end
`endif

      // Period run for the 8-bit instance, with a/b still scoreboarded.
      reset_step("per_rst");
      per_en = 1'b1;
      run_seq(300, "period");
      per_en = 1'b0;

      distinct = 0;
      for (int i = 0; i < 255; i++) if (seen[i] == 1) distinct++;
      check("w8_first_repeat", 8'(first_ret), 8'd255);
      n_vec++;
      if (distinct != 255) begin
         n_bad++;
         $display("FAIL w8_distinct: got %0d, expected 255", distinct);
      end
      n_vec++;
      if (ff_seen != 0) begin
         n_bad++;
         $display("FAIL w8_allones_seen: got %0d, expected 0", ff_seen);
      end
      n_vec++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Watchdog.
   initial begin
      #50000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
